mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised multicycle load/store unit between the datapath and a handshaked data memory port.
- Handles byte/half/word/doubleword accesses on an N-bit little-endian bus, with per-lane byte enables and sign/zero extension of loads.
- Detects misaligned accesses and memory timeouts.
- Generalises the fixed 2-bit memwrite/dtype memory control of the current core to a variable-latency bus with explicit completion.

Parameters:
N, 64, data/address width; legal values 32 or 64; byte lanes = N/8.
MAXWAIT, 16, maximum cycles mem_req stays high without mem_ack before abort; legal range ≥1.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  access request; sampled only in IDLE
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 double
lbu  in  1  1=zero-extend load, 0=sign-extend
addr  in  N  byte address
wdata  in  N  store data, right-justified
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
rdata  out  N  extended load result, held until next load done
misalign  out  1  valid with done
timeout  out  1  valid with done
mem_addr  out  N  addr with low log2(N/8) bits cleared
mem_wdata  out  N  store lanes replicated across the bus
mem_be  out  N/8  byte enables
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_ack  in  1  bus completion; mem_rdata valid in the same cycle
mem_rdata  in  N  bus read data
state  out  2  debug: 0 IDLE, 1 BUS, 2 DONE

Behaviour:
Reset (next edge after reset=1, from any state, including mid-BUS):
- state=IDLE.
- All outputs 0, rdata=0, wait counter=0.
- mem_req low at that edge; any later mem_ack is ignored.

Accept:
- start=1 in IDLE latches we, size, lbu, addr, wdata.
- start is ignored in BUS and DONE.
- Access width W = 1<<size bytes.
- off = addr mod (N/8).
- Illegal if off mod W ≠ 0, or if size=11 and N=32.

Legal access:
- IDLE→BUS at the accept edge.
- In BUS: mem_req=1, mem_we=we, mem_addr, mem_be = ((1<<W)-1)<<off, mem_wdata = low W bytes of wdata replicated across all lanes.
- These outputs are stable for the whole of BUS.

BUS:
- On mem_ack=1: capture load data, go to DONE; mem_req=0 from the next cycle.
- Minimum latency: start at cycle t → mem_req at t+1 → done at t+2 when ack arrives at t+1.
- Wait counter increments each BUS cycle without ack.
- If MAXWAIT BUS cycles pass with no ack: go to DONE with timeout=1, rdata=0 (loads).
- An ack in the MAXWAIT-th cycle wins over timeout.

Illegal access:
- IDLE→DONE directly with misalign=1.
- mem_req is never asserted; rdata is unchanged.

DONE:
- Lasts one cycle: done=1, with misalign and timeout valid; then →IDLE.
- A new start is accepted from the following cycle.

Load data:
- Take mem_rdata >> (8·off), keep the low W bytes.
- Extend to N bits: sign-extend if lbu=0, zero-extend if lbu=1.
- Size 11 with N=64 passes the data through unmodified.

Stores:
- rdata is unchanged.

Test Plan:
- Reset with N=64 → busy, done, mem_req, mem_be, rdata, state all 0. Assert reset mid-BUS → mem_req 0 next cycle, state=0, no done pulse.
- Load byte, addr=0x1003, lbu=0, mem_rdata=0x0000_0000_8000_0000, ack on first BUS cycle → mem_addr=0x1000, mem_be=0x08, done 2 cycles after start, rdata=0xFFFF_FFFF_FFFF_FF80. Repeat with lbu=1 → rdata=0x80.
- Store half, addr=0x2006, wdata=0x1234, ack after 3 wait cycles → mem_be=0xC0, mem_we=1, mem_wdata=0x1234_1234_1234_1234, mem_req high exactly 4 cycles, done 1 cycle after ack.
- Load word, addr=0x2002 → done and misalign high at start+1, mem_req never high, rdata unchanged. Load double with N=32 → misalign.
- MAXWAIT=8, no ack → mem_req high exactly 8 cycles, then done with timeout=1 and rdata=0. Ack in cycle 8 → normal completion, timeout=0.
- start pulses every cycle during a BUS wait → only the first is accepted; exactly one done per accepted access; back-to-back start in the cycle after done is accepted.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit: aligns, masks and replicates accesses onto a
// handshaked N-bit little-endian memory port, with misalign and timeout detection.
module mem_access_unit #(
  parameter int N       = 64,
  parameter int MAXWAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             lbu,
  input  logic [N-1:0]     addr,
  input  logic [N-1:0]     wdata,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     rdata,
  output logic             misalign,
  output logic             timeout,
  output logic [N-1:0]     mem_addr,
  output logic [N-1:0]     mem_wdata,
  output logic [N/8-1:0]   mem_be,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  input  logic [N-1:0]     mem_rdata,
  output logic [1:0]       state
);

  localparam int LANES = N / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  state_t           st;
  logic             we_q;
  logic [1:0]       size_q;
  logic             lbu_q;
  logic [OFF_W-1:0] off_q;
  logic [CNT_W-1:0] wait_cnt;

  // One bit per byte lane that belongs to an access of the given size.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] sz);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (i < (1 << sz));
    return m;
  endfunction

  // Keep the low (1<<sz) bytes of d and sign- or zero-extend them to N bits.
  function automatic logic [N-1:0] extend(input logic [N-1:0] d,
                                          input logic [1:0] sz,
                                          input logic zx);
    logic [N-1:0] m;
    logic         s;
    int           top;
    for (int i = 0; i < LANES; i++) m[8*i +: 8] = (i < (1 << sz)) ? 8'hFF : 8'h00;
    top = (8 << sz) - 1;
    if (top > N - 1) top = N - 1;
    s = d[top];
    return (d & m) | ((s && !zx) ? ~m : '0);
  endfunction

  // Copy the low (1<<sz) bytes of wd into every lane group of the bus.
  function automatic logic [N-1:0] replicate(input logic [N-1:0] wd,
                                             input logic [1:0] sz);
    logic [N-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = wd[8*(i % (1 << sz)) +: 8];
    return r;
  endfunction

  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] align_mask;
  logic             illegal;
  logic [N-1:0]     shifted;

  assign off        = addr[OFF_W-1:0];
  assign align_mask = OFF_W'((32'd1 << size) - 32'd1);
  assign illegal    = ((off & align_mask) != '0) || (size == 2'b11 && N == 32);
  assign shifted    = mem_rdata >> {off_q, 3'b000};
  assign busy       = (st != IDLE);
  assign state      = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      lbu_q     <= 1'b0;
      off_q     <= '0;
      wait_cnt  <= '0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (st)
        IDLE: begin
          done     <= 1'b0;
          misalign <= 1'b0;
          timeout  <= 1'b0;
          if (start) begin
            we_q     <= we;
            size_q   <= size;
            lbu_q    <= lbu;
            off_q    <= off;
            wait_cnt <= '0;
            if (illegal) begin
              st       <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              st        <= BUS;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[N-1:OFF_W], {OFF_W{1'b0}}};
              mem_be    <= lane_mask(size) << off;
              mem_wdata <= replicate(wdata, size);
            end
          end
        end
        BUS: begin
          // An ack in the final allowed cycle takes priority over the timeout.
          if (mem_ack || wait_cnt == CNT_W'(MAXWAIT - 1)) begin
            st        <= DONE;
            done      <= 1'b1;
            timeout   <= !mem_ack;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if (!we_q) rdata <= mem_ack ? extend(shifted, size_q, lbu_q) : '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          st       <= IDLE;
          done     <= 1'b0;
          misalign <= 1'b0;
          timeout  <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 64-bit instance with MAXWAIT=8 plus a
// 32-bit instance for the width-dependent misalign case.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, we, lbu, mem_ack;
  logic [1:0]  size;
  logic [63:0] addr, wdata, mem_rdata;
  logic        busy, done, misalign, timeout, mem_req, mem_we;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic [1:0]  state;

  logic        start32, we32, lbu32, mem_ack32;
  logic [1:0]  size32;
  logic [31:0] addr32, wdata32, mem_rdata32;
  logic        busy32, done32, misalign32, timeout32, mem_req32, mem_we32;
  logic [31:0] rdata32, mem_addr32, mem_wdata32;
  logic [3:0]  mem_be32;
  logic [1:0]  state32;

  int errors = 0;
  int checks = 0;
  int reqcnt;

  always #5 clk = ~clk;

  mem_access_unit #(.N(64), .MAXWAIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .size(size), .lbu(lbu),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .timeout(timeout), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state(state)
  );

  mem_access_unit #(.N(32), .MAXWAIT(8)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .we(we32), .size(size32), .lbu(lbu32),
    .addr(addr32), .wdata(wdata32), .busy(busy32), .done(done32), .rdata(rdata32),
    .misalign(misalign32), .timeout(timeout32), .mem_addr(mem_addr32),
    .mem_wdata(mem_wdata32), .mem_be(mem_be32), .mem_req(mem_req32), .mem_we(mem_we32),
    .mem_ack(mem_ack32), .mem_rdata(mem_rdata32), .state(state32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic zx,
                       input logic [63:0] a, input logic [63:0] d);
    start = 1'b1; we = w; size = sz; lbu = zx; addr = a; wdata = d;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; we = 0; lbu = 0; size = 0; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    start32 = 0; we32 = 0; lbu32 = 0; size32 = 0; addr32 = 0; wdata32 = 0;
    mem_ack32 = 0; mem_rdata32 = 0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_be", 64'(mem_be), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_state", 64'(state), 64'd0);

    // signed byte load, ack on first BUS cycle
    issue(1'b0, 2'b00, 1'b0, 64'h1003, 64'd0);
    check("lb_state", 64'(state), 64'd1);
    check("lb_req", 64'(mem_req), 64'd1);
    check("lb_addr", mem_addr, 64'h1000);
    check("lb_be", 64'(mem_be), 64'h08);
    check("lb_we", 64'(mem_we), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h0000_0000_8000_0000;
    tick();
    mem_ack = 1'b0;
    check("lb_done", 64'(done), 64'd1);
    check("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_mis", 64'(misalign), 64'd0);
    check("lb_to", 64'(timeout), 64'd0);
    check("lb_req_off", 64'(mem_req), 64'd0);
    tick();
    check("lb_idle", 64'(state), 64'd0);
    check("lb_done_off", 64'(done), 64'd0);

    // unsigned byte load
    issue(1'b0, 2'b00, 1'b1, 64'h1003, 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lbu_done", 64'(done), 64'd1);
    check("lbu_rdata", rdata, 64'h80);
    tick();

    // half store, ack after 3 wait cycles
    issue(1'b1, 2'b01, 1'b0, 64'h2006, 64'h1234);
    check("sh_be", 64'(mem_be), 64'hC0);
    check("sh_we", 64'(mem_we), 64'd1);
    check("sh_wdata", mem_wdata, 64'h1234_1234_1234_1234);
    check("sh_addr", mem_addr, 64'h2000);
    reqcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req) reqcnt++;
      if (i == 3) mem_ack = 1'b1;
      else check("sh_nodone", 64'(done), 64'd0);
      tick();
    end
    mem_ack = 1'b0;
    check("sh_reqcnt", 64'(reqcnt), 64'd4);
    check("sh_done", 64'(done), 64'd1);
    check("sh_rdata_kept", rdata, 64'h80);
    tick();

    // misaligned word load
    issue(1'b0, 2'b10, 1'b0, 64'h2002, 64'd0);
    check("mw_done", 64'(done), 64'd1);
    check("mw_mis", 64'(misalign), 64'd1);
    check("mw_req", 64'(mem_req), 64'd0);
    check("mw_state", 64'(state), 64'd2);
    check("mw_rdata", rdata, 64'h80);
    tick();
    check("mw_idle", 64'(state), 64'd0);

    // double on a 32-bit bus is always illegal
    start32 = 1'b1; size32 = 2'b11; addr32 = 32'h0;
    tick();
    start32 = 1'b0;
    check("d32_done", 64'(done32), 64'd1);
    check("d32_mis", 64'(misalign32), 64'd1);
    check("d32_req", 64'(mem_req32), 64'd0);
    tick();

    // timeout: no ack at all
    issue(1'b0, 2'b10, 1'b0, 64'h3004, 64'd0);
    reqcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (mem_req) reqcnt++;
      tick();
    end
    check("to_reqcnt", 64'(reqcnt), 64'd8);
    check("to_done", 64'(done), 64'd1);
    check("to_flag", 64'(timeout), 64'd1);
    check("to_rdata", rdata, 64'd0);
    tick();

    // ack in the last allowed cycle wins over timeout
    issue(1'b0, 2'b10, 1'b0, 64'h3004, 64'd0);
    mem_rdata = 64'h89AB_CDEF_0000_0000;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    check("a8_done", 64'(done), 64'd1);
    check("a8_to", 64'(timeout), 64'd0);
    check("a8_rdata", rdata, 64'hFFFF_FFFF_89AB_CDEF);
    tick();

    // start held high: ignored in BUS/DONE, accepted again in the following IDLE
    start = 1'b1; we = 1'b0; size = 2'b11; lbu = 1'b0; addr = 64'h4000;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    addr = 64'h4008;
    tick();
    check("bb_state", 64'(state), 64'd1);
    check("bb_addr_held", mem_addr, 64'h4000);
    check("bb_nodone", 64'(done), 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("bb_done1", 64'(done), 64'd1);
    check("bb_rdata1", rdata, 64'h0123_4567_89AB_CDEF);
    tick();
    check("bb_idle", 64'(state), 64'd0);
    check("bb_done_off", 64'(done), 64'd0);
    tick();
    start = 1'b0;
    check("bb_accept2", 64'(state), 64'd1);
    check("bb_addr2", mem_addr, 64'h4008);
    mem_rdata = 64'hFEDC_BA98_7654_3210;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("bb_done2", 64'(done), 64'd1);
    check("bb_rdata2", rdata, 64'hFEDC_BA98_7654_3210);
    tick();

    // reset in the middle of a bus wait
    issue(1'b0, 2'b00, 1'b0, 64'h5000, 64'd0);
    check("mr_req", 64'(mem_req), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_req_off", 64'(mem_req), 64'd0);
    check("mr_state", 64'(state), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_rdata", rdata, 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("mr_ack_ignored", 64'(done), 64'd0);
    check("mr_state2", 64'(state), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
